sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 136 +++++++++++++
 tb/tb_sram_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Host request pipeline and bulk-clear engine in front of a synchronous single-port SRAM.
// Responses return two edges after acceptance; the clear engine fills every word with one value.
module sram_ctrl #(
  parameter int WORDS = 1536,
  parameter int AW    = 11,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          sram_csb,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do
);

  localparam logic [AW:0]   WORDS_C = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LAST_C  = AW'(WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] clr_data_q;
  logic          p1_valid_q, p1_rd_q, p1_err_q;
  logic          p2_valid_q, p2_rd_q, p2_err_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          clr_busy_q, clr_done_q;
  logic          sram_csb_q, sram_web_q, sram_oeb_q;
  logic [AW-1:0] sram_a_q;
  logic [DW-1:0] sram_di_q;
  logic          accept, in_range;

  assign req_ready = (state_q == IDLE) && !clr_start && !rst;
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < WORDS_C);
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clr_data_q  <= '0;
      p1_valid_q  <= 1'b0;
      p1_rd_q     <= 1'b0;
      p1_err_q    <= 1'b0;
      p2_valid_q  <= 1'b0;
      p2_rd_q     <= 1'b0;
      p2_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      sram_csb_q  <= 1'b1;
      sram_web_q  <= 1'b1;
      sram_oeb_q  <= 1'b1;
      sram_a_q    <= '0;
      sram_di_q   <= '0;
    end else begin
      sram_oeb_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      sram_csb_q  <= 1'b1;
      sram_web_q  <= 1'b1;
      // Response pipeline runs independently of the FSM so in-flight reads survive a clear.
      p1_valid_q  <= accept;
      p1_rd_q     <= !req_we;
      p1_err_q    <= !in_range;
      p2_valid_q  <= p1_valid_q;
      p2_rd_q     <= p1_rd_q;
      p2_err_q    <= p1_err_q;
      rsp_valid_q <= p2_valid_q;
      rsp_err_q   <= p2_valid_q && p2_err_q;
      rsp_rdata_q <= (p2_valid_q && p2_rd_q && !p2_err_q) ? sram_do : '0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_data_q <= clr_data;
            cnt_q      <= '0;
            sram_csb_q <= 1'b0;
            sram_web_q <= 1'b0;
            sram_a_q   <= '0;
            sram_di_q  <= clr_data;
          end else if (accept && in_range) begin
            sram_csb_q <= 1'b0;
            sram_web_q <= ~req_we;
            sram_a_q   <= req_addr;
            sram_di_q  <= req_wdata;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_C) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_d;
            sram_csb_q <= 1'b0;
            sram_web_q <= 1'b0;
            sram_a_q   <= cnt_d;
            sram_di_q  <= clr_data_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign sram_csb  = sram_csb_q;
  assign sram_web  = sram_web_q;
  assign sram_oeb  = sram_oeb_q;
  assign sram_a    = sram_a_q;
  assign sram_di   = sram_di_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural synchronous SRAM attached.
module tb_sram_ctrl;
  localparam int WORDS = 1536;
  localparam int AW    = 11;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          clr_start, clr_busy, clr_done;
  logic [DW-1:0] clr_data;
  logic          sram_csb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do;

  sram_ctrl #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (!sram_csb && int'(sram_a) < WORDS) begin
      if (!sram_web) mem[sram_a] <= sram_di;
      else           sram_do     <= mem[sram_a];
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
    string         name;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, stray = 0;
  int   busy_cnt = 0, clr_idx = 0, clr_bad = 0, done_cnt = 0;
  logic [DW-1:0] clr_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response and tracks the clear sweep.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        stray++;
      end else begin
        e_mon = sbq.pop_front();
        check($sformatf("%s_rdata", e_mon.name), 32'(rsp_rdata), 32'(e_mon.rdata));
        check($sformatf("%s_err", e_mon.name), 32'(rsp_err), 32'(e_mon.err));
        check($sformatf("%s_latency", e_mon.name), cyc, e_mon.cyc);
      end
    end
    if (clr_busy === 1'b1) begin
      busy_cnt++;
      if (sram_csb !== 1'b0 || sram_web !== 1'b0 || int'(sram_a) != clr_idx || sram_di !== clr_val)
        clr_bad++;
      clr_idx++;
    end
    if (clr_done === 1'b1) done_cnt++;
  end

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] er, input logic ee, input string nm,
                        input bit push, output logic done_at_acc);
    int   n = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    #1;
    while (req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    done_at_acc = clr_done;
    if (n >= 3000) begin
      check($sformatf("%s_accept_timeout", nm), 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      e.rdata = er; e.err = ee; e.cyc = cyc + 3; e.name = nm;
      sbq.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic start_clear(input logic [DW-1:0] v);
    clr_val = v; clr_idx = 0; busy_cnt = 0; clr_bad = 0; done_cnt = 0;
    clr_data = v; clr_start = 1'b1;
  endtask

  logic done_flag;
  int   n_wait;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    clr_start = 1'b0; clr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_csb", 32'(sram_csb), 1);
    check("rst_oeb", 32'(sram_oeb), 1);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    check("oeb_after_rst", 32'(sram_oeb), 0);
    check("ready_idle", 32'(req_ready), 1);

    // Write then read-back of the same word on consecutive cycles.
    do_req(1'b1, 11'h005, 8'hA5, 8'h00, 1'b0, "wr5", 1, done_flag);
    check("wr5_csb", 32'(sram_csb), 0);
    check("wr5_web", 32'(sram_web), 0);
    check("wr5_a", 32'(sram_a), 32'h005);
    check("wr5_di", 32'(sram_di), 32'hA5);
    do_req(1'b0, 11'h005, 8'h00, 8'hA5, 1'b0, "rd5", 1, done_flag);
    check("rd5_csb", 32'(sram_csb), 0);
    check("rd5_web", 32'(sram_web), 1);

    // First out-of-range address; no SRAM access may happen.
    do_req(1'b0, 11'h600, 8'h00, 8'h00, 1'b1, "rd600", 1, done_flag);
    check("rd600_csb", 32'(sram_csb), 1);
    check("rd600_web", 32'(sram_web), 1);
    do_req(1'b1, 11'h7FF, 8'h77, 8'h00, 1'b1, "wr7ff", 1, done_flag);
    check("wr7ff_csb", 32'(sram_csb), 1);

    for (int i = 0; i < 8; i++)
      do_req(1'b1, AW'(i), 8'h10 + 8'(i), 8'h00, 1'b0, $sformatf("wrb%0d", i), 1, done_flag);
    for (int i = 0; i < 8; i++)
      do_req(1'b0, AW'(i), 8'h00, 8'h10 + 8'(i), 1'b0, $sformatf("rdb%0d", i), 1, done_flag);

    // Read in flight when the clear starts, then a request colliding with clr_start.
    do_req(1'b0, 11'h003, 8'h00, 8'h13, 1'b0, "rd3_inflight", 1, done_flag);
    start_clear(8'h3C);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h000;
    #1;
    check("ready_low_on_clr_start", 32'(req_ready), 0);
    @(negedge clk);
    clr_start = 1'b0; clr_data = 8'hFF;
    do_req(1'b0, 11'h000, 8'h00, 8'h3C, 1'b0, "clr_rd0", 1, done_flag);
    check("accept_right_after_clear", 32'(done_flag), 1);
    check("clr_busy_cycles", busy_cnt, WORDS);
    check("clr_sweep_bad", clr_bad, 0);
    check("clr_done_pulses", done_cnt, 1);
    do_req(1'b0, 11'h5FF, 8'h00, 8'h3C, 1'b0, "clr_rd5ff", 1, done_flag);

    // A clr_start while already clearing must not restart the sweep.
    @(negedge clk);
    start_clear(8'hC3);
    @(negedge clk);
    clr_start = 1'b0;
    repeat (10) @(negedge clk);
    clr_start = 1'b1; clr_data = 8'h00;
    @(negedge clk);
    clr_start = 1'b0;
    n_wait = 0;
    while (clr_busy === 1'b1 && n_wait < 3000) begin @(negedge clk); n_wait++; end
    @(negedge clk);
    check("clr2_busy_cycles", busy_cnt, WORDS);
    check("clr2_sweep_bad", clr_bad, 0);
    check("clr2_done_pulses", done_cnt, 1);

    // Reset mid-clear.
    start_clear(8'h5A);
    @(negedge clk);
    clr_start = 1'b0;
    n_wait = 0;
    while (!(clr_busy === 1'b1 && sram_a == 11'd100) && n_wait < 3000) begin
      @(negedge clk); n_wait++;
    end
    check("reach_clr_addr100", 32'(sram_a), 32'd100);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_csb", 32'(sram_csb), 1);
    check("mid_rst_web", 32'(sram_web), 1);
    check("mid_rst_oeb", 32'(sram_oeb), 1);
    check("mid_rst_a", 32'(sram_a), 0);
    check("mid_rst_di", 32'(sram_di), 0);
    check("mid_rst_busy", 32'(clr_busy), 0);
    check("mid_rst_done", 32'(clr_done), 0);
    check("mid_rst_rsp", {29'd0, rsp_valid, rsp_err, 1'b0}, 0);
    check("mid_rst_rdata", 32'(rsp_rdata), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_cnt, 0);
    check("busy_after_rst", 32'(clr_busy), 0);

    // Pending read killed by reset must never respond.
    do_req(1'b0, 11'h005, 8'h00, 8'h00, 1'b0, "rd_aborted", 0, done_flag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_req(1'b1, 11'h010, 8'h96, 8'h00, 1'b0, "wr10", 1, done_flag);
    do_req(1'b0, 11'h010, 8'h00, 8'h96, 1'b0, "rd10", 1, done_flag);
    repeat (6) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    check("stray_responses", stray, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
